pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program-counter unit for the PCP core: holds PC, selects the next fetch address.
//  Supports sequential, absolute/relative conditional branch, call/return via internal LIFO, and halt/resume.
//  Sits between Control_Unit (op/cond) and instrMem (pc); replaces the PC register + HLT/BRA mux pair.
// PARAMETERS
//  ADDR_W      10  PC / target width; all PC arithmetic is modulo 2**ADDR_W
//  OFF_W       8   signed relative-branch offset width (two's complement, sign-extended to ADDR_W)
//  STACK_DEPTH 4   return-stack entries (>=1)
//  RESET_ADDR  0   PC value after reset
// PORTS
//  clk        in   1                  clock, rising edge
//  rst        in   1                  asynchronous reset, active-low
//  en         in   1                  advance enable; 0 = stall, all state held, op/resume ignored
//  pc_op      in   3                  0 SEQ,1 JMP,2 BRR,3 CALL,4 RET,5 HLT,6/7 reserved (=SEQ)
//  cond       in   1                  branch condition for JMP/BRR (from flags)
//  target     in   ADDR_W             absolute address for JMP/CALL
//  offset     in   OFF_W              signed offset for BRR
//  resume     in   1                  leave HALT (sampled only when en=1)
//  pc         out  ADDR_W             registered current PC to instrMem
//  next_pc    out  ADDR_W             combinational value pc will take at next qualifying edge
//  halted     out  1                  state==HALT
//  faulted    out  1                  state==FAULT
//  stk_depth  out  $clog2(STACK_DEPTH+1)  valid entries in return stack
//  err_ovf    out  1                  sticky: CALL attempted with stack full
//  err_unf    out  1                  sticky: RET attempted with stack empty
// BEHAVIOUR
//  Reset (rst=0, async): pc=RESET_ADDR, state=RUN, stk_depth=0, halted=faulted=err_ovf=err_unf=0.
//  All updates on rising clk when en=1; en=0 -> next_pc=pc, nothing changes.
//  FSM RUN/HALT/FAULT:
//   RUN  SEQ/reserved: pc<=pc+1.
//        JMP: pc<=cond?target:pc+1.  BRR: pc<=cond?pc+sext(offset):pc+1 (wraps).
//        CALL: not full -> push pc+1, pc<=target; full -> pc held, err_ovf<=1, ->FAULT.
//        RET: not empty -> pc<=top, pop; empty -> pc held, err_unf<=1, ->FAULT.
//        HLT: pc held, ->HALT (halted=1 from next cycle).
//   HALT pc held, pc_op ignored; resume=1 -> RUN with pc<=pc+1 same edge.
//   FAULT pc held, stack frozen, exits only via reset.
//  Latency: op sampled at edge N -> new pc visible after edge N, i.e. one cycle.
//  Wrap: pc+1 from 2**ADDR_W-1 gives 0; CALL at top address pushes 0.
//  Stack depth exactly STACK_DEPTH; a CALL filling the last slot is legal, the next faults.
//  Reset mid-operation (any state) restores reset values at once; stack contents discarded.
// STRUCTURE
//  Shared package pcp_pkg: pc_op encodings (PC_SEQ..PC_HLT), state encodings (ST_RUN/HALT/FAULT).
//  Sub-module ret_stack: LIFO, ports push/pop/din/dout/depth/full/empty, params W/DEPTH,
//   same clk/rst; push when full and pop when empty are ignored inside it (guarded by parent).
//  Top holds pc register, FSM, next_pc mux, sticky error flags.
// TESTING (ADDR_W=10, OFF_W=8, STACK_DEPTH=4, RESET_ADDR=0)
//  Reset then 5 SEQ with en=1 -> pc 1,2,3,4,5; en=0 for 3 cycles mid-run -> pc holds at 3.
//  pc=10: JMP target=0x200 cond=0 -> 11; cond=1 -> 0x200; BRR offset=-4 at pc=0x200 -> 0x1FC.
//  pc=0x3FF SEQ -> 0; BRR offset=+2 at 0x3FF -> 0x001.
//  CALL 0x100 at pc 5, CALL 0x180 at 0x100, RET, RET -> pc 0x100,0x180,0x101,6; depth 1,2,1,0.
//  5 CALLs -> depth 4, 5th: err_ovf=1, faulted=1, pc held; RET from empty after reset -> err_unf=1.
//  HLT at pc 7 -> halted=1, pc 7 for 4 cycles; resume=1 -> pc 8, halted=0; async rst while HALT -> pc 0.

Source files
------------

// File: rtl/pcp_pkg.sv
// Shared encodings for the PCP program-counter sequencer: branch/call operations and FSM states.
package pcp_pkg;

  typedef enum logic [2:0] {
    PC_SEQ  = 3'd0,
    PC_JMP  = 3'd1,
    PC_BRR  = 3'd2,
    PC_CALL = 3'd3,
    PC_RET  = 3'd4,
    PC_HLT  = 3'd5
  } pc_op_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } pc_state_e;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO for the sequencer. Pushing into a full stack or popping an empty one is ignored.
module ret_stack #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               din_i,
  output logic [W-1:0]               dout_o,
  output logic [$clog2(DEPTH+1)-1:0] depth_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [DW-1:0] depth_q, depth_d;
  logic [DW-1:0] top_q;
  logic          do_push, do_pop;

  assign full_o  = (depth_q == DW'(DEPTH));
  assign empty_o = (depth_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o && !push_i;
  assign top_q   = depth_q - DW'(1);
  assign dout_o  = empty_o ? '0 : mem_q[top_q[AW-1:0]];
  assign depth_o = depth_q;

  always_comb begin
    depth_d = depth_q;
    if (do_push) begin
      depth_d = depth_q + DW'(1);
    end else if (do_pop) begin
      depth_d = depth_q - DW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

  // Contents need no reset: entries above depth_q are never read.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[depth_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: PC register, next-fetch mux, call/return stack and RUN/HALT/FAULT control.
//
// state    | meaning
// ST_RUN   | executing; pc_op selects next pc
// ST_HALT  | pc frozen until resume
// ST_FAULT | stack over/underflow; pc and stack frozen until reset
module pc_sequencer
  import pcp_pkg::*;
#(
  parameter int              ADDR_W      = 10,
  parameter int              OFF_W       = 8,
  parameter int              STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             en_i,
  input  logic [2:0]                       pc_op_i,
  input  logic                             cond_i,
  input  logic [ADDR_W-1:0]                target_i,
  input  logic [OFF_W-1:0]                 offset_i,
  input  logic                             resume_i,
  output logic [ADDR_W-1:0]                pc_o,
  output logic [ADDR_W-1:0]                next_pc_o,
  output logic                             halted_o,
  output logic                             faulted_o,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stk_depth_o,
  output logic                             err_ovf_o,
  output logic                             err_unf_o
);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_unf_q, err_unf_d;

  logic              push, pop;
  logic [ADDR_W-1:0] stk_top;
  logic              stk_full, stk_empty;

  pc_op_e                   op;
  logic [ADDR_W-1:0]        pc_inc;
  logic signed [OFF_W-1:0]  off_s;
  logic [ADDR_W-1:0]        off_ext;

  assign op      = pc_op_e'(pc_op_i);
  assign pc_inc  = pc_q + ADDR_W'(1);
  assign off_s   = offset_i;
  assign off_ext = ADDR_W'(off_s);

  ret_stack #(
    .W     (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (pc_inc),
    .dout_o  (stk_top),
    .depth_o (stk_depth_o),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    err_ovf_d = err_ovf_q;
    err_unf_d = err_unf_q;
    push      = 1'b0;
    pop       = 1'b0;
    if (en_i) begin
      unique case (state_q)
        ST_RUN: begin
          case (op)
            PC_JMP:  pc_d = cond_i ? target_i : pc_inc;
            PC_BRR:  pc_d = cond_i ? (pc_q + off_ext) : pc_inc;
            PC_CALL: begin
              if (stk_full) begin
                err_ovf_d = 1'b1;
                state_d   = ST_FAULT;
              end else begin
                push = 1'b1;
                pc_d = target_i;
              end
            end
            PC_RET: begin
              if (stk_empty) begin
                err_unf_d = 1'b1;
                state_d   = ST_FAULT;
              end else begin
                pop  = 1'b1;
                pc_d = stk_top;
              end
            end
            PC_HLT:  state_d = ST_HALT;
            default: pc_d = pc_inc;
          endcase
        end
        ST_HALT: begin
          if (resume_i) begin
            state_d = ST_RUN;
            pc_d    = pc_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_ADDR;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  assign pc_o      = pc_q;
  assign next_pc_o = pc_d;
  assign halted_o  = (state_q == ST_HALT);
  assign faulted_o = (state_q == ST_FAULT);
  assign err_ovf_o = err_ovf_q;
  assign err_unf_o = err_unf_q;

endmodule
